register_bank_loader: RTL
=========================

REGISTER_BANK_LOADER -- requirements
Module: register_bank_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each stored word.
REQ-002 Parameter DEPTH, default 64: number of registers, legal range 2..1024.
REQ-003 Parameter ADDR_WIDTH, default 6: address width, SHALL equal ceil(log2(DEPTH)).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cs  input  1  chip select; when low, no state changes except reset.
REQ-007 clear  input  1  synchronous clear of all registers and load state.
REQ-008 mode  input  1  write mode: 0 = sequential stream load, 1 = addressed write.
REQ-009 s_valid  input  1  write request valid.
REQ-010 s_ready  output  1  write request accepted this cycle when high together with s_valid.
REQ-011 s_data  input  DATA_WIDTH  write data.
REQ-012 s_addr  input  ADDR_WIDTH  write address, used only when mode=1.
REQ-013 rd_addr  input  ADDR_WIDTH  read-port address.
REQ-014 rd_data  output  DATA_WIDTH  registered read-port data.
REQ-015 dout  output  DATA_WIDTH*DEPTH  flattened register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-016 count  output  ADDR_WIDTH+1  number of words stream-loaded since the last clear or reset.
REQ-017 full  output  1  high when count equals DEPTH.
REQ-018 done  output  1  single-cycle pulse on the cycle after the DEPTH-th stream write.

Function
REQ-019 FSM states: LOAD and FULL; reset and clear enter LOAD.
REQ-020 s_ready SHALL be combinational: cs & ~clear & (mode | (state==LOAD)).
REQ-021 A write is accepted when s_valid & s_ready.
REQ-022 Stream write (mode=0): s_data is stored at wr_ptr, then wr_ptr and count increment by 1.
REQ-023 On the accepted stream write with count==DEPTH-1: state becomes FULL, full rises next cycle, done pulses high for exactly one cycle next cycle, wr_ptr wraps to 0.
REQ-024 In FULL, stream writes are refused (s_ready=0 when mode=0); registers, count and wr_ptr hold.
REQ-025 Addressed write (mode=1): s_data is stored at s_addr in either state; wr_ptr, count, full and state are unchanged.
REQ-026 Writes to an address >= DEPTH are accepted and discarded.
REQ-027 A mode change between writes preserves wr_ptr and count; a stream load resumes where it stopped.
REQ-028 clear with cs high: all registers, wr_ptr and count go to 0, state goes to LOAD, full and done go low next cycle; clear has priority over a same-cycle write.
REQ-029 clear with cs low is ignored.
REQ-030 rd_data SHALL equal the register at rd_addr one cycle after rd_addr is presented (latency 1), updated only when cs is high.
REQ-031 When a write and a read target the same address in the same cycle, rd_data returns the pre-write value.
REQ-032 When rd_addr >= DEPTH, rd_data returns 0.
REQ-033 dout SHALL reflect the register contents directly, with written data visible the cycle after the write.

Reset
REQ-034 While rst_n is low, all registers, rd_data, wr_ptr and count SHALL be 0, full and done SHALL be 0, and state SHALL be LOAD, independent of clk.
REQ-035 A reset asserted mid-load discards the partial load; after release the first stream write lands at address 0.

Verification
REQ-036 Stream fill: cs=1, mode=0, 64 consecutive writes of data=i+1 -> dout word i = i+1; count=64; full=1; done high for exactly one cycle; s_ready=0 afterwards.
REQ-037 Backpressure: in FULL, mode=0, s_valid=1, data=0xDEAD -> no register changes, count stays 64; then switch to mode=1 and write 0xBEEF at addr 5 -> word 5 = 0xBEEF, count stays 64.
REQ-038 Mode interleave: 10 stream writes, then addressed write 0x1234 at addr 40, then 1 stream write of 0x00AA -> word 10 = 0x00AA, word 40 = 0x1234, count=11.
REQ-039 Clear priority: clear=1 together with an accepted stream write -> all words 0, count=0, full=0; the next stream write lands at addr 0.
REQ-040 Read port: write 0x5555 at addr 3, then in the same cycle read addr 3 and write 0x6666 to addr 3 -> rd_data=0x5555 one cycle later and 0x6666 on the following read; with cs=0, rd_data and all state hold.
REQ-041 Async reset: assert rst_n low between clock edges after 20 stream writes -> all outputs 0 immediately; after release, the first write of 0x0077 lands at word 0 and count=1.

Source files
------------

// File: rtl/register_bank_loader.sv
// Register bank with two write paths: a sequential stream loader that fills the
// bank from address 0 upward, and an addressed write port. A registered read
// port and a flattened view of every register are provided.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   cs                chip select; when low only reset can change state
//   clear             synchronous clear of registers and load state (needs cs)
//   mode              0 = stream load at wr_ptr, 1 = write at s_addr
//   s_valid/s_ready   write handshake; s_ready is combinational
//   s_data, s_addr    write data and address (address used only when mode=1)
//   rd_addr, rd_data  read port, one cycle latency, 0 for out-of-range
//   dout              all registers, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   count             words stream-loaded since last clear/reset
//   full              count == DEPTH
//   done              one-cycle pulse after the DEPTH-th stream write
module register_bank_loader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cs,
    input  logic                        clear,
    input  logic                        mode,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic [ADDR_WIDTH-1:0]       s_addr,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [DATA_WIDTH*DEPTH-1:0] dout,
    output logic [ADDR_WIDTH:0]         count,
    output logic                        full,
    output logic                        done
);

    if (ADDR_WIDTH != $clog2(DEPTH) || DEPTH < 2 || DEPTH > 1024) begin : gen_param_check
        $error("register_bank_loader: illegal DEPTH/ADDR_WIDTH combination");
    end

    typedef enum logic [0:0] {
        StLoad = 1'b0,
        StFull = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH:0] DepthC = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LastC  = DepthC - (ADDR_WIDTH + 1)'(1);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
    logic [DATA_WIDTH-1:0]   regs_d [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

    logic wr_en;
    logic s_addr_ok;
    logic rd_addr_ok;

    assign s_ready    = cs & ~clear & (mode | (state_q == StLoad));
    assign wr_en      = s_valid & s_ready;
    // Zero-extend so the compare also works when DEPTH is a power of two.
    assign s_addr_ok  = ({1'b0, s_addr} < DepthC);
    assign rd_addr_ok = ({1'b0, rd_addr} < DepthC);

    always_comb begin
        state_d  = state_q;
        regs_d   = regs_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        done_d   = 1'b0;

        if (cs) begin
            if (clear) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    regs_d[i] = '0;
                end
                wr_ptr_d = '0;
                count_d  = '0;
                state_d  = StLoad;
            end else if (wr_en) begin
                if (mode) begin
                    // Out-of-range addresses are accepted but dropped.
                    if (s_addr_ok) begin
                        regs_d[s_addr] = s_data;
                    end
                end else begin
                    regs_d[wr_ptr_q] = s_data;
                    count_d          = count_q + (ADDR_WIDTH + 1)'(1);
                    if (count_q == LastC) begin
                        state_d  = StFull;
                        wr_ptr_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Reads sample the pre-write contents, so a same-cycle write is not bypassed.
    always_comb begin
        rd_data_d = rd_data_q;
        if (cs) begin
            rd_data_d = rd_addr_ok ? regs_q[rd_addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StLoad;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            regs_q    <= regs_d;
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            dout[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign rd_data = rd_data_q;
    assign count   = count_q;
    assign full    = (count_q == DepthC);
    assign done    = done_q;

endmodule
